// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Shared definitions for the whack-a-mole referee:
//   - referee FSM state encoding
//   - default timing / lives parameters
//   - LFSR seed value
//   - helper that picks the next mole hole from the LFSR
// -----------------------------------------------------------------------------
package whack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_UP    = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int WINDOW_TICKS_DEF = 8;
    localparam int PAUSE_TICKS_DEF  = 4;
    localparam int LIVES_INIT_DEF   = 3;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Next hole comes from the low LFSR bits, bumped by one when it would
    // repeat the previous hole so the player always sees the mole move.
    function automatic logic [1:0] pick_pos(input logic [7:0] lfsr,
                                            input logic [1:0] prev_pos);
        logic [1:0] cand;
        cand = lfsr[1:0];
        if (cand == prev_pos) begin
            cand = cand + 2'd1;
        end
        return cand;
    endfunction

endpackage

// File: rtl/whack_lfsr8.sv
// -----------------------------------------------------------------------------
// whack_lfsr8
// Free-running 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4), stepping
// every clock. Used as the random source for mole placement.
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset, loads LFSR_SEED
//   lfsr_state out  current 8-bit LFSR state
// -----------------------------------------------------------------------------
module whack_lfsr8
    import whack_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    output logic [7:0] lfsr_state
);

    logic [7:0] r_lfsr;
    logic       w_feedback;

    // Taps 8,6,5,4 (1-based) map to bits 7,5,4,3.
    assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    assign lfsr_state = r_lfsr;

endmodule

// File: rtl/whack_referee.sv
// -----------------------------------------------------------------------------
// whack_referee
// Referee for a four-hole whack-a-mole game. Places moles, times the whack
// window, judges key presses, keeps score and lives, and reports game over.
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset (abandons any game silently)
//   start      in   one-cycle pulse: begin a new game (honoured in IDLE/OVER)
//   tick       in   one-cycle timing enable from the rate divider
//   whack_key  in   [3:0] player keys, active-high, already synchronised
//   mole_pos   out  [1:0] hole index of the current mole
//   mole_up    out  mole visible and whackable (registered, high in UP)
//   whacked    out  one-cycle pulse on a correct hit
//   missed     out  one-cycle pulse on a wrong key or timeout
//   score      out  [7:0] hits this game, saturating at 255
//   lives      out  [1:0] remaining lives
//   game_over  out  level, high while the game is over
// -----------------------------------------------------------------------------
module whack_referee
    import whack_pkg::*;
#(
    parameter int WINDOW_TICKS = WINDOW_TICKS_DEF,
    parameter int PAUSE_TICKS  = PAUSE_TICKS_DEF,
    parameter int LIVES_INIT   = LIVES_INIT_DEF
)(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       tick,
    input  logic [3:0] whack_key,
    output logic [1:0] mole_pos,
    output logic       mole_up,
    output logic       whacked,
    output logic       missed,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam logic [7:0] W_WINDOW = 8'(WINDOW_TICKS);
    localparam logic [7:0] W_PAUSE  = 8'(PAUSE_TICKS);
    localparam logic [1:0] W_LIVES  = 2'(LIVES_INIT);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t     r_state;
    logic [7:0] r_timer;
    logic [7:0] r_score;
    logic [1:0] r_lives;
    logic [1:0] r_mole_pos;
    logic       r_mole_up;
    logic       r_whacked;
    logic       r_missed;
    logic       r_game_over;
    logic [3:0] r_key_prev;

    // -------------------------------------------------------------------------
    // Combinational next-state values
    // -------------------------------------------------------------------------
    state_t     w_state_next;
    logic [7:0] w_timer_next;
    logic [7:0] w_score_next;
    logic [1:0] w_lives_next;
    logic [1:0] w_mole_pos_next;
    logic       w_whacked_next;
    logic       w_missed_next;
    logic       w_miss;

    logic [7:0] w_lfsr;
    logic [1:0] w_new_pos;
    logic       w_key_event;
    logic       w_key_match;

    whack_lfsr8 u_lfsr (
        .clk        (clk),
        .resetn     (resetn),
        .lfsr_state (w_lfsr)
    );

    // Only a fresh 0->1 transition on any key counts; holding keys is silent.
    assign w_key_event = |(whack_key & ~r_key_prev);
    // Whole vector must be exactly the mole's one-hot code, so chords miss.
    assign w_key_match = (whack_key == (4'b0001 << r_mole_pos));
    assign w_new_pos   = pick_pos(w_lfsr, r_mole_pos);

    always_comb begin
        w_state_next    = r_state;
        w_timer_next    = r_timer;
        w_score_next    = r_score;
        w_lives_next    = r_lives;
        w_mole_pos_next = r_mole_pos;
        w_whacked_next  = 1'b0;
        w_missed_next   = 1'b0;
        w_miss          = 1'b0;

        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    w_score_next    = 8'd0;
                    w_lives_next    = W_LIVES;
                    w_timer_next    = W_WINDOW;
                    w_mole_pos_next = w_new_pos;
                    w_state_next    = ST_UP;
                end
            end

            ST_UP: begin
                // A key event takes priority over a coincident timeout tick.
                if (w_key_event) begin
                    if (w_key_match) begin
                        w_whacked_next = 1'b1;
                        w_score_next   = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                        w_timer_next   = W_PAUSE;
                        w_state_next   = ST_PAUSE;
                    end else begin
                        w_miss = 1'b1;
                    end
                end else if (tick) begin
                    if (r_timer == 8'd1) begin
                        w_miss = 1'b1;
                    end else begin
                        w_timer_next = r_timer - 8'd1;
                    end
                end

                if (w_miss) begin
                    w_missed_next = 1'b1;
                    w_lives_next  = r_lives - 2'd1;
                    if (r_lives == 2'd1) begin
                        w_state_next = ST_OVER;
                    end else begin
                        w_timer_next = W_PAUSE;
                        w_state_next = ST_PAUSE;
                    end
                end
            end

            ST_PAUSE: begin
                if (tick) begin
                    if (r_timer == 8'd1) begin
                        w_mole_pos_next = w_new_pos;
                        w_timer_next    = W_WINDOW;
                        w_state_next    = ST_UP;
                    end else begin
                        w_timer_next = r_timer - 8'd1;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register. mole_up / game_over are registered decodes of the next
    // state so they line up exactly with the state they describe.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_timer     <= 8'd0;
            r_score     <= 8'd0;
            r_lives     <= 2'd0;
            r_mole_pos  <= 2'd0;
            r_mole_up   <= 1'b0;
            r_whacked   <= 1'b0;
            r_missed    <= 1'b0;
            r_game_over <= 1'b0;
            r_key_prev  <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_score     <= w_score_next;
            r_lives     <= w_lives_next;
            r_mole_pos  <= w_mole_pos_next;
            r_mole_up   <= (w_state_next == ST_UP);
            r_whacked   <= w_whacked_next;
            r_missed    <= w_missed_next;
            r_game_over <= (w_state_next == ST_OVER);
            r_key_prev  <= whack_key;
        end
    end

    assign mole_pos  = r_mole_pos;
    assign mole_up   = r_mole_up;
    assign whacked   = r_whacked;
    assign missed    = r_missed;
    assign score     = r_score;
    assign lives     = r_lives;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_whack_referee.sv
// -----------------------------------------------------------------------------
// tb_whack_referee
// Directed scenarios plus randomized play for whack_referee. Every cycle the
// DUT outputs are compared with a game-level reference model that follows the
// rules directly (phase, countdown, score, lives, LFSR-based hole choice).
// -----------------------------------------------------------------------------
module tb_whack_referee;

    localparam int P_IDLE  = 0;
    localparam int P_UP    = 1;
    localparam int P_PAUSE = 2;
    localparam int P_OVER  = 3;
    localparam int WIN     = 8;
    localparam int PAU     = 4;
    localparam int LIV     = 3;

    logic       clk       = 1'b0;
    logic       resetn    = 1'b0;
    logic       start     = 1'b0;
    logic       tick      = 1'b0;
    logic [3:0] whack_key = 4'd0;
    logic [1:0] mole_pos;
    logic       mole_up;
    logic       whacked;
    logic       missed;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;

    whack_referee dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .tick      (tick),
        .whack_key (whack_key),
        .mole_pos  (mole_pos),
        .mole_up   (mole_up),
        .whacked   (whacked),
        .missed    (missed),
        .score     (score),
        .lives     (lives),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    int         m_phase;
    int         m_timer;
    int         m_score;
    int         m_lives;
    int         m_pos;
    int         m_lfsr;
    bit         m_wh;
    bit         m_mi;
    logic [3:0] m_prev;

    function automatic void model_reset();
        m_phase = P_IDLE; m_timer = 0; m_score = 0; m_lives = 0; m_pos = 0;
        m_lfsr = 'hA5; m_wh = 0; m_mi = 0; m_prev = 4'd0;
    endfunction

    function automatic int model_pick();
        int cand;
        cand = m_lfsr % 4;
        if (cand == m_pos) cand = (cand + 1) % 4;
        return cand;
    endfunction

    function automatic void model_miss();
        m_mi = 1;
        m_lives = m_lives - 1;
        if (m_lives == 0) begin
            m_phase = P_OVER;
        end else begin
            m_timer = PAU;
            m_phase = P_PAUSE;
        end
    endfunction

    function automatic void model_step(input bit st, input bit tk, input logic [3:0] k);
        bit key_ev;
        int fb;
        key_ev = (k & ~m_prev) != 4'd0;
        m_wh = 0;
        m_mi = 0;
        if (m_phase == P_IDLE || m_phase == P_OVER) begin
            if (st) begin
                m_score = 0; m_lives = LIV; m_timer = WIN;
                m_pos = model_pick(); m_phase = P_UP;
            end
        end else if (m_phase == P_UP) begin
            if (key_ev) begin
                if (int'(k) == (1 << m_pos)) begin
                    m_wh = 1;
                    if (m_score < 255) m_score = m_score + 1;
                    m_timer = PAU;
                    m_phase = P_PAUSE;
                end else begin
                    model_miss();
                end
            end else if (tk) begin
                if (m_timer == 1) model_miss();
                else m_timer = m_timer - 1;
            end
        end else begin
            if (tk) begin
                if (m_timer == 1) begin
                    m_pos = model_pick(); m_timer = WIN; m_phase = P_UP;
                end else begin
                    m_timer = m_timer - 1;
                end
            end
        end
        m_prev = k;
        fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 'hFF;
    endfunction

    function automatic logic [15:0] dut_vec();
        return {mole_pos, mole_up, whacked, missed, score, lives, game_over};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {2'(m_pos), (m_phase == P_UP), m_wh, m_mi, 8'(m_score), 2'(m_lives),
                (m_phase == P_OVER)};
    endfunction

    function automatic logic [3:0] onehot(input int p);
        return 4'(1 << p);
    endfunction

    // ------------------------------------------------------------ stimulus
    // Called just after a falling edge: drive, let the rising edge happen,
    // advance the model, then compare on the next falling edge.
    task automatic cyc(input bit st, input bit tk, input logic [3:0] k);
        start = st; tick = tk; whack_key = k;
        @(posedge clk);
        if (resetn) model_step(st, tk, k);
        @(negedge clk);
        check_eq("cycle", dut_vec(), exp_vec());
    endtask

    task automatic do_reset();
        start = 0; tick = 0; whack_key = 4'd0;
        resetn = 1'b0;
        #1;
        model_reset();
        check_eq("rst_async", dut_vec(), 16'h0000);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_up(input int budget);
        int n;
        n = 0;
        while (m_phase != P_UP && n < budget) begin
            cyc(0, 1, 4'd0);
            n++;
        end
        check_eq("reach_up", 16'(mole_up), 16'd1);
    endtask

    initial begin
        logic [3:0] k;
        logic [3:0] k2;
        logic [1:0] old_pos;
        bit         st;
        bit         tk;

        model_reset();
        @(negedge clk);

        // Correct hit, pause length, mole moves
        do_reset();
        cyc(0, 0, 4'd0);
        cyc(1, 0, 4'd0);
        check_eq("up_after_start", 16'({mole_up, lives}), 16'({1'b1, 2'd3}));
        k = onehot(m_pos);
        old_pos = mole_pos;
        cyc(0, 1, 4'd0);
        cyc(0, 0, k);
        check_eq("hit_pulse", 16'({whacked, missed}), 16'b10);
        check_eq("hit_score", 16'(score), 16'd1);
        check_eq("hit_lives", 16'(lives), 16'd3);
        cyc(0, 0, 4'd0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 4'd0);
        check_eq("still_paused", 16'(mole_up), 16'd0);
        cyc(0, 1, 4'd0);
        check_eq("up_after_pause", 16'(mole_up), 16'd1);
        check_eq("new_pos_differs", 16'(mole_pos != old_pos), 16'd1);
        $display("scenario hit_and_pause complete");

        // Timeout after the full window
        do_reset();
        cyc(1, 0, 4'd0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 4'd0);
        check_eq("no_early_timeout", 16'(missed), 16'd0);
        cyc(0, 1, 4'd0);
        check_eq("timeout_pulse", 16'({whacked, missed}), 16'b01);
        check_eq("timeout_lives", 16'({score, lives}), 16'({8'd0, 2'd2}));
        $display("scenario timeout complete");

        // Three wrong keys end the game; later input changes nothing
        do_reset();
        cyc(1, 0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) for (int j = 0; j < PAU; j++) cyc(0, 1, 4'd0);
            cyc(0, 0, onehot((m_pos + 1) % 4));
            check_eq("wrong_key_lives", 16'({missed, lives}), 16'({1'b1, 2'(2 - i)}));
            cyc(0, 0, 4'd0);
        end
        check_eq("game_over", 16'({game_over, mole_up}), 16'b10);
        for (int i = 0; i < 6; i++) cyc(0, i % 2, 4'(i + 1));
        check_eq("over_held", 16'({score, lives, game_over}), 16'({8'd0, 2'd0, 1'b1}));
        $display("scenario three_misses complete");

        // Key edge coincides with the final tick: hit wins
        do_reset();
        cyc(1, 0, 4'd0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 4'd0);
        cyc(0, 1, onehot(m_pos));
        check_eq("key_beats_timeout", 16'({whacked, missed}), 16'b10);
        $display("scenario key_vs_timeout complete");

        // Held key across pause gives no event; fresh press does
        do_reset();
        cyc(1, 0, 4'd0);
        k = onehot(m_pos);
        cyc(0, 0, k);
        for (int i = 0; i < PAU; i++) cyc(0, 1, k);
        cyc(0, 0, k);
        cyc(0, 0, k);
        check_eq("held_no_event", 16'({whacked, missed, mole_up}), 16'b001);
        cyc(0, 0, 4'd0);
        k2 = onehot(m_pos);
        cyc(0, 0, k2);
        check_eq("repress_event", 16'({whacked, missed}), 16'b10);
        cyc(0, 0, k2);
        check_eq("single_pulse", 16'({whacked, missed}), 16'b00);
        $display("scenario held_key complete");

        // Score saturation, then reset while a mole is up
        do_reset();
        cyc(1, 0, 4'd0);
        for (int i = 0; i < 258; i++) begin
            wait_up(20);
            cyc(0, 0, onehot(m_pos));
            cyc(0, 0, 4'd0);
        end
        check_eq("score_sat", 16'(score), 16'd255);
        wait_up(20);
        cyc(0, 0, onehot(m_pos));
        check_eq("sat_hit_pulse", 16'({whacked, score}), 16'({1'b1, 8'd255}));
        wait_up(20);
        do_reset();
        cyc(0, 0, 4'd0);
        check_eq("no_pulse_after_rst", 16'({whacked, missed, mole_up}), 16'b000);
        $display("scenario saturate_and_reset complete");

        // Randomized play
        k = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            st = ($urandom_range(0, 29) == 0);
            tk = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) k = onehot(m_pos);
                else k = 4'($urandom_range(0, 15));
            end
            cyc(st, tk, k);
        end
        $display("scenario random complete");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/whack_referee.md
WHACK_REFEREE -- requirements
Module: whack_referee

Interface
REQ-001 Parameter WINDOW_TICKS, default 8: ticks a mole stays up before a miss is declared (1..255).
REQ-002 Parameter PAUSE_TICKS, default 4: ticks of empty board between moles (1..255).
REQ-003 Parameter LIVES_INIT, default 3: lives at game start (1..3).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse from game control: begin new game.
REQ-007 tick  input  1  one-cycle timing enable from the rate divider.
REQ-008 whack_key  input  4  player keys, active-high, already synchronised to clk.
REQ-009 mole_pos  output  2  index of the current mole hole.
REQ-010 mole_up  output  1  mole visible and whackable.
REQ-011 whacked  output  1  one-cycle pulse: correct hit; drives control's go path.
REQ-012 missed  output  1  one-cycle pulse: wrong key or timeout.
REQ-013 score  output  8  hits this game.
REQ-014 lives  output  2  remaining lives.
REQ-015 game_over  output  1  level, high while the game is over; feeds control's game_over.

Function
REQ-016 FSM states SHALL be IDLE, UP, PAUSE, OVER.
REQ-017 IDLE: start -> score=0, lives=LIVES_INIT, timer=WINDOW_TICKS, new mole_pos, go to UP; otherwise stay.
REQ-018 Key event SHALL be a rising edge on any whack_key bit (previous key vector registered); held keys generate no further events.
REQ-019 UP, key event, key vector exactly one-hot matching mole_pos -> whacked pulse, score+1 saturating at 255, timer=PAUSE_TICKS, go to PAUSE.
REQ-020 UP, key event with wrong or multiple keys -> miss.
REQ-021 UP, tick with timer==1 and no key event -> miss (timeout); otherwise tick decrements timer.
REQ-022 Miss: missed pulse, lives-1; lives reaching 0 -> OVER, else timer=PAUSE_TICKS, go to PAUSE.
REQ-023 Key event and timeout in the same cycle: key event SHALL win.
REQ-024 PAUSE: mole_up=0; key events ignored; tick decrements timer; at timer==1 on tick, new mole_pos, timer=WINDOW_TICKS, go to UP.
REQ-025 OVER: game_over=1, mole_up=0, score and lives held; start -> same action as REQ-017.
REQ-026 start SHALL be ignored in UP and PAUSE.
REQ-027 whacked/missed SHALL assert in the cycle after the edge that registers the event; never both in one cycle.
REQ-028 mole_up SHALL be a registered output, high exactly while in UP.
REQ-029 New mole_pos = lfsr[1:0]; if equal to the previous mole_pos, use (lfsr[1:0]+1) mod 4.
REQ-030 LFSR: 8-bit maximal length (taps 8,6,5,4), advances every cycle regardless of state.

Reset
REQ-031 resetn low SHALL immediately force: state IDLE, mole_pos=0, mole_up=0, whacked=0, missed=0, score=0, lives=0, game_over=0, timer=0, key history=0, LFSR=8'hA5.
REQ-032 Reset mid-game SHALL abandon the game without any whacked or missed pulse.

Structure
REQ-033 State encoding and parameter defaults SHALL live in shared package whack_pkg.
REQ-034 LFSR SHALL be sub-module whack_lfsr8 (clk, resetn, 8-bit state out).

Verification
REQ-035 Reset, start, key matching mole_pos within 3 ticks -> whacked one cycle later, score=1, lives=3, PAUSE for 4 ticks, then mole_up=1 at a different mole_pos.
REQ-036 Start, no key for 8 ticks -> missed pulse, lives=2, score=0.
REQ-037 Three consecutive wrong keys -> lives 2,1,0, game_over=1 after the third; further keys do not change score or lives.
REQ-038 Key edge in the same cycle as the final tick -> whacked only, no missed.
REQ-039 Key held across PAUSE into UP -> no event; release and re-press -> one event.
REQ-040 Force score=255, correct hit -> score stays 255; resetn pulsed in UP -> all outputs 0 with no pulse.
